imem_fetch_ctrl: RTL
====================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter LAT, default 2: fixed instruction-BRAM read latency in cycles; legal range 1..8.
REQ-002 Parameter DEPTH, default 4: instruction-buffer entries; DEPTH >= LAT+2 SHALL hold (elaboration error otherwise).
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 Port: clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 Port: imem_req, output, 1, read request to the BRAM this cycle.
REQ-007 Port: imem_addr, output, 32, byte address of the request; bits [1:0] always 0.
REQ-008 Port: imem_rdata, input, 32, read data, valid exactly LAT cycles after the request.
REQ-009 Port: redirect_valid, input, 1, branch/jump taken in Execute (E_PCSrc).
REQ-010 Port: redirect_pc, input, 32, new fetch target (E_pcTarget).
REQ-011 Port: f_valid, output, 1, buffer head holds an instruction for Decode.
REQ-012 Port: f_instr, output, 32, instruction at buffer head.
REQ-013 Port: f_pc, output, 32, byte address of f_instr.
REQ-014 Port: d_ready, input, 1, Decode accepts (the inverse of stallD); transfer = f_valid && d_ready.

Function
REQ-015 A request issued in cycle t SHALL have its imem_rdata sampled in cycle t+LAT, written to the buffer at the end of t+LAT, and presented on f_valid from cycle t+LAT+1 when the buffer is otherwise empty.
REQ-016 A LAT-deep shift pipe SHALL carry {valid, pc} per request, so every returned word is paired with its own address.
REQ-017 imem_req SHALL assert iff (in-flight count + buffer count) < DEPTH and redirect_valid is low; the current-cycle pop SHALL NOT be credited.
REQ-018 On issue, the fetch PC SHALL advance by 4, wrapping modulo 2^32.
REQ-019 In a redirect_valid cycle, the block SHALL load the fetch PC with {redirect_pc[31:2],2'b00}, clear all pipe valid bits, empty the buffer, drive f_valid low from the next cycle, and issue no request that cycle.
REQ-020 After a redirect, the first request SHALL be for the redirect target in the next cycle; returning data for cleared pipe slots SHALL be discarded.
REQ-021 Push and pop in the same cycle SHALL be legal and SHALL leave the count unchanged; the credit rule SHALL make overflow impossible.
REQ-022 Buffer order SHALL be strictly FIFO; f_instr and f_pc SHALL be driven from registers or the buffer head, not combinationally from imem_rdata.
REQ-023 With d_ready held high and no redirects, the block SHALL sustain one instruction per cycle after the initial LAT+1 fill.
REQ-024 When f_valid is low, f_instr SHALL be 32'h0000_0013 (NOP) and f_pc SHALL hold its last value.

Reset
REQ-025 While rst_n is low: fetch PC = RESET_PC, pipe valid bits = 0, buffer empty, imem_req = 0, imem_addr = RESET_PC, f_valid = 0, f_instr = NOP, f_pc = RESET_PC.
REQ-026 The first request (address RESET_PC) SHALL issue in the first cycle after rst_n deasserts.
REQ-027 If reset asserts while requests are in flight, their data SHALL never appear on f_valid.

Structure
REQ-028 The NOP encoding, XLEN=32 and the RESET_PC default SHALL live in the shared rv_pkg package.
REQ-029 The buffer SHALL be a separate sub-module, fetch_fifo (parameter DEPTH, show-ahead head, count output).

Verification
REQ-030 LAT=2, imem holding addi words at 0x00..0x1C, d_ready=1 -> f_pc sequence 0,4,8,... first valid at cycle 3 after reset release, then one per cycle with no gaps.
REQ-031 d_ready=0 for 10 cycles -> at most DEPTH requests outstanding plus buffered, imem_req low once credits are exhausted, and no word lost or duplicated after release.
REQ-032 redirect_valid with redirect_pc=0x10 while 2 requests are in flight -> the next f_valid carries f_pc=0x10, and the words from the stale in-flight requests never appear.
REQ-033 redirect_pc=0x13 -> imem_addr=0x10.
REQ-034 Sweep LAT=1,2,4 with DEPTH=LAT+2 running the count-to-3 beq loop on the rv_pl core -> stores leave dmem[0]=3 and dmem[1]=2.
REQ-035 rst_n pulsed low mid-stream with 3 requests in flight -> f_valid=0 and imem_req=0 during reset, and after release the first f_pc=RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: data width, NOP encoding, reset PC.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Number of set bits in an 8-bit vector (in-flight request count).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead instruction buffer: {instr, pc} entries, strict FIFO order,
// synchronous flush, simultaneous push/pop allowed.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_instr,
    input  logic [XLEN-1:0]            push_pc,
    input  logic                       pop,
    output logic [XLEN-1:0]            head_instr,
    output logic [XLEN-1:0]            head_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem_instr_r [DEPTH];
    logic [XLEN-1:0]  mem_pc_r    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Entry storage: written on push unless the buffer is being flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_r[i] <= NOP;
                mem_pc_r[i]    <= {XLEN{1'b0}};
            end
        end else if (push && !flush) begin
            mem_instr_r[wr_ptr_r] <= push_instr;
            mem_pc_r[wr_ptr_r]    <= push_pc;
        end else begin
            mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
            mem_pc_r[wr_ptr_r]    <= mem_pc_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= push ? next_ptr(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop  ? next_ptr(rd_ptr_r) : rd_ptr_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_instr = mem_instr_r[rd_ptr_r];
    assign head_pc    = mem_pc_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch front end: issues BRAM reads against a credit limit,
// tracks each request's PC through a LAT-deep pipe, and buffers returned
// words for Decode. Redirects flush everything in flight.
module imem_fetch_ctrl
    import rv_pkg::*;
#(
    parameter int              LAT      = 2,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            f_valid,
    output logic [XLEN-1:0] f_instr,
    output logic [XLEN-1:0] f_pc,
    input  logic            d_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("imem_fetch_ctrl: LAT must be in 1..8");
    end
    if (DEPTH < LAT + 2) begin : g_bad_depth
        $error("imem_fetch_ctrl: DEPTH must be at least LAT+2");
    end

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  last_pc_r;
    logic [LAT-1:0]   pipe_valid_r;
    logic [XLEN-1:0]  pipe_pc_r [LAT];
    logic [3:0]       inflight_s;
    logic [31:0]      occ_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [XLEN-1:0]  head_instr_s;
    logic [XLEN-1:0]  head_pc_s;
    logic             push_s;
    logic             pop_s;
    logic             unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Credit: in-flight plus buffered must stay below DEPTH; this cycle's pop is not counted.
    always_comb begin
        inflight_s = popcount8(8'(pipe_valid_r));
        occ_s      = 32'(inflight_s) + 32'(fifo_count_s);
        if (rst_n && !redirect_valid && (occ_s < 32'(DEPTH))) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr = pc_r;

    // Fetch PC: load word-aligned redirect target, else advance on each issued request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= START_PC;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Request valid pipe: reset or redirect kills every outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_r <= {LAT{1'b0}};
        end else if (redirect_valid) begin
            pipe_valid_r <= {LAT{1'b0}};
        end else begin
            pipe_valid_r[0] <= imem_req;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
            end
        end
    end

    // Request PC pipe: travels alongside the valid bits so data pairs with its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_pc_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            pipe_pc_r[0] <= pc_r;
            for (int i = 1; i < LAT; i++) begin
                pipe_pc_r[i] <= pipe_pc_r[i-1];
            end
        end
    end

    assign push_s = pipe_valid_r[LAT-1] && !redirect_valid;
    assign pop_s  = f_valid && d_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_instr (imem_rdata),
        .push_pc    (pipe_pc_r[LAT-1]),
        .pop        (pop_s),
        .head_instr (head_instr_s),
        .head_pc    (head_pc_s),
        .count      (fifo_count_s)
    );

    // Decode-facing view of the buffer head; NOP and held PC when empty.
    always_comb begin
        if (fifo_count_s != {CNT_W{1'b0}}) begin
            f_valid = 1'b1;
            f_instr = head_instr_s;
            f_pc    = head_pc_s;
        end else begin
            f_valid = 1'b0;
            f_instr = NOP;
            f_pc    = last_pc_r;
        end
    end

    // Remember the last presented PC so f_pc holds while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_r <= START_PC;
        end else begin
            last_pc_r <= f_pc;
        end
    end

endmodule
